// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_like_arbiter                                          |
// | Description : Two-master (inst/data), one-slave sram-like arbiter that   |
// |               shares the uncached sram-like->AXI bridge. Data side has   |
// |               fixed priority; a consecutive-grant cap keeps inst moving. |
// |               The winning command is latched so the bridge sees stable   |
// |               wr/size/addr/wdata for the whole transaction.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_like_arbiter #(
    // Max consecutive data grants while inst_req waits (1..15).
    parameter int DATA_CONSEC_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    // Instruction-side master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    // Data-side master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    // Bridge side
    output logic        sraml_req,
    output logic        sraml_wr,
    output logic [1:0]  sraml_size,
    output logic [31:0] sraml_addr,
    output logic [31:0] sraml_wdata,
    input  logic [31:0] sraml_rdata,
    input  logic        sraml_addr_ok,
    input  logic        sraml_data_ok
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] c_consec_max = 4'(DATA_CONSEC_MAX);

    // Owner encoding: 0 = inst, 1 = data.
    localparam logic c_owner_inst = 1'b0;
    localparam logic c_owner_data = 1'b1;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_owner;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_consec;

    logic        w_consec_full;
    logic        w_win_data;
    logic        w_win_inst;
    logic        w_grant;
    logic        w_addr_ok;
    logic        w_data_ok;

    // Arbitration: data has priority unless inst has been passed over
    // DATA_CONSEC_MAX times in a row while it was waiting.
    always_comb begin
        w_consec_full = (r_consec == c_consec_max);
        w_win_data    = data_req && !(inst_req && w_consec_full);
        w_win_inst    = !w_win_data && inst_req;
        w_grant       = (r_state == ST_IDLE) && (w_win_data || w_win_inst);
    end

    // State register; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake steering; only the owner ever sees ok pulses.
    always_comb begin
        w_next_state = r_state;
        sraml_req    = 1'b0;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_data || w_win_inst) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                sraml_req = 1'b1;
                if (sraml_addr_ok) begin
                    w_addr_ok = 1'b1;
                    // A bridge that completes in the accept cycle finishes
                    // the whole transaction here.
                    if (sraml_data_ok) begin
                        w_data_ok    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sraml_data_ok) begin
                    w_data_ok    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command latch: captured once at grant so master inputs may change freely
    // after addr_ok without disturbing what the bridge sees.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= c_owner_inst;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_grant) begin
            if (w_win_data) begin
                r_owner <= c_owner_data;
                r_wr    <= data_wr;
                r_size  <= data_size;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else begin
                r_owner <= c_owner_inst;
                r_wr    <= inst_wr;
                r_size  <= inst_size;
                r_addr  <= inst_addr;
                r_wdata <= inst_wdata;
            end
        end
    end

    // Consecutive-data-grant counter: counts only grants that overtook a
    // waiting inst request; any other grant restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_consec <= 4'd0;
        end else if (w_grant) begin
            if (w_win_data && inst_req) begin
                if (!w_consec_full) begin
                    r_consec <= r_consec + 4'd1;
                end
            end else begin
                r_consec <= 4'd0;
            end
        end
    end

    // Bridge command comes only from the latch, never from live master inputs.
    always_comb begin
        sraml_wr    = r_wr;
        sraml_size  = r_size;
        sraml_addr  = r_addr;
        sraml_wdata = r_wdata;
    end

    // Per-master handshakes; rdata is a plain mirror qualified by data_ok.
    always_comb begin
        inst_addr_ok = w_addr_ok && (r_owner == c_owner_inst);
        inst_data_ok = w_data_ok && (r_owner == c_owner_inst);
        data_addr_ok = w_addr_ok && (r_owner == c_owner_data);
        data_data_ok = w_data_ok && (r_owner == c_owner_data);
        inst_rdata   = sraml_rdata;
        data_rdata   = sraml_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_like_arbiter                                       |
// | Description : Scoreboard bench for sram_like_arbiter: master drivers,    |
// |               bridge stub and an independent handshake monitor.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_like_arbiter;

    localparam int DATA_CONSEC_MAX = 4;

    typedef struct packed {
        logic        m;      // 0 = inst, 1 = data
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        m;
        logic [31:0] rdata;
        logic [31:0] addr;   // bridge address still presented at data_ok
        logic [31:0] wdata;  // bridge wdata still presented at data_ok
    } resp_t;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        sraml_req, sraml_wr, sraml_addr_ok, sraml_data_ok;
    logic [1:0]  sraml_size;
    logic [31:0] sraml_addr, sraml_wdata, sraml_rdata;

    cmd_t  inst_mq[$];
    cmd_t  data_mq[$];
    cmd_t  cmd_q[$];
    resp_t resp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ok_cyc = 0;
    int prev_ok_cyc = 0;
    int same_cnt = 0;
    int same_base = 0;
    int addr_lat = 0;
    int data_lat = 0;
    bit same_cycle = 0;
    int stub_st = 0;
    int stub_acnt = 0;
    int stub_dcnt = 0;
    bit drv_ai, drv_ad;
    cmd_t  got_c, exp_c;
    resp_t got_r, exp_r;

    sram_like_arbiter #(.DATA_CONSEC_MAX(DATA_CONSEC_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .sraml_req(sraml_req), .sraml_wr(sraml_wr), .sraml_size(sraml_size),
        .sraml_addr(sraml_addr), .sraml_wdata(sraml_wdata), .sraml_rdata(sraml_rdata),
        .sraml_addr_ok(sraml_addr_ok), .sraml_data_ok(sraml_data_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bridge memory contents: boot word at 0xBFC00000, halves swapped elsewhere.
    function automatic logic [31:0] stub_rd(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
        return {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_inst(input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        inst_mq.push_back('{m: 1'b0, wr: wr, size: size, addr: addr, wdata: wdata});
    endtask

    task automatic send_data(input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        data_mq.push_back('{m: 1'b1, wr: wr, size: size, addr: addr, wdata: wdata});
    endtask

    task automatic expect_txn(input logic m, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
        cmd_q.push_back('{m: m, wr: wr, size: size, addr: addr, wdata: wdata});
        resp_q.push_back('{m: m, rdata: rdata, addr: addr, wdata: wdata});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((inst_mq.size() + data_mq.size() + cmd_q.size() + resp_q.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 68'(inst_mq.size() + data_mq.size() + cmd_q.size() + resp_q.size()), 68'd0);
        repeat (2) @(negedge clk);
    endtask

    // Bridge stub: addr_ok after addr_lat REQ cycles, data_ok data_lat cycles later
    // (or in the same cycle as addr_ok when same_cycle is set).
    initial begin
        sraml_addr_ok = 1'b0;
        sraml_data_ok = 1'b0;
        sraml_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            sraml_addr_ok = 1'b0;
            sraml_data_ok = 1'b0;
            sraml_rdata   = 32'h0;
            if (!resetn) begin
                stub_st = 0; stub_acnt = 0; stub_dcnt = 0;
            end else if (stub_st == 0) begin
                if (sraml_req) begin
                    if (stub_acnt >= addr_lat) begin
                        stub_acnt = 0;
                        sraml_addr_ok = 1'b1;
                        if (same_cycle) begin
                            sraml_data_ok = 1'b1;
                            sraml_rdata   = stub_rd(sraml_addr);
                        end else begin
                            stub_st = 1;
                        end
                    end else begin
                        stub_acnt++;
                    end
                end
            end else begin
                if (stub_dcnt >= data_lat) begin
                    stub_dcnt = 0;
                    stub_st = 0;
                    sraml_data_ok = 1'b1;
                    sraml_rdata   = stub_rd(sraml_addr);
                end else begin
                    stub_dcnt++;
                end
            end
        end
    end

    // Master drivers: hold the head command until its addr_ok, then move on;
    // with nothing queued the inputs go to junk values with req low.
    initial begin
        drv_ai = 1'b0;
        drv_ad = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '1; inst_wdata = '1;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '1; data_wdata = '1;
        forever begin
            @(negedge clk);
            drv_ai = inst_addr_ok;
            drv_ad = data_addr_ok;
            @(posedge clk);
            #1;
            if (drv_ai && inst_mq.size() != 0) inst_mq.delete(0);
            if (drv_ad && data_mq.size() != 0) data_mq.delete(0);
            if (inst_mq.size() != 0) begin
                inst_req = 1'b1; inst_wr = inst_mq[0].wr; inst_size = inst_mq[0].size;
                inst_addr = inst_mq[0].addr; inst_wdata = inst_mq[0].wdata;
            end else begin
                inst_req = 1'b0; inst_wr = 1'b1; inst_size = 2'd3;
                inst_addr = 32'hFFFF_FFFF; inst_wdata = 32'hFFFF_FFFF;
            end
            if (data_mq.size() != 0) begin
                data_req = 1'b1; data_wr = data_mq[0].wr; data_size = data_mq[0].size;
                data_addr = data_mq[0].addr; data_wdata = data_mq[0].wdata;
            end else begin
                data_req = 1'b0; data_wr = 1'b1; data_size = 2'd3;
                data_addr = 32'hFFFF_FFFF; data_wdata = 32'hFFFF_FFFF;
            end
        end
    end

    // Monitor: every ok pulse pops the scoreboard and is checked against it.
    initial begin
        forever begin
            @(negedge clk);
            if (inst_addr_ok && data_addr_ok) begin
                check("both_addr_ok", 68'({inst_addr_ok, data_addr_ok}), 68'd0);
            end else if (inst_addr_ok || data_addr_ok) begin
                got_c = {data_addr_ok, sraml_wr, sraml_size, sraml_addr, sraml_wdata};
                if (cmd_q.size() == 0) begin
                    check("unexpected_addr_ok", 68'(got_c), 68'h0_DEAD_0000_DEAD_0000);
                end else begin
                    exp_c = cmd_q.pop_front();
                    check("cmd", 68'(got_c), 68'(exp_c));
                    check("cmd_req", 68'(sraml_req), 68'd1);
                end
                prev_ok_cyc = last_ok_cyc;
                last_ok_cyc = cyc;
            end
            if (inst_data_ok && data_data_ok) begin
                check("both_data_ok", 68'({inst_data_ok, data_data_ok}), 68'd0);
            end else if (inst_data_ok || data_data_ok) begin
                got_r = {data_data_ok, (data_data_ok ? data_rdata : inst_rdata), sraml_addr, sraml_wdata};
                if (resp_q.size() == 0) begin
                    check("unexpected_data_ok", 68'(got_r.m), 68'h2);
                end else begin
                    exp_r = resp_q.pop_front();
                    check("resp", 68'(got_r[96:32]), 68'(exp_r[96:32]));
                    check("resp_wdata_stable", 68'(got_r.wdata), 68'(exp_r.wdata));
                end
            end
            if ((inst_addr_ok && inst_data_ok) || (data_addr_ok && data_data_ok)) same_cnt++;
        end
    end

    initial begin
        string order;
        int di;
        int ii;
        logic [31:0] a;
        resetn = 1'b0;

        // 1: reset held with both masters requesting; data wins first.
        send_inst(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        send_data(1'b0, 2'd2, 32'h0000_0200, 32'h0);
        expect_txn(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h0200_0000);
        expect_txn(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h0100_0000);
        repeat (4) begin
            @(negedge clk);
            check("reset_quiet", 68'({sraml_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 68'd0);
        end
        resetn = 1'b1;
        @(posedge clk);
        #2;
        check("first_grant_latency", 68'(sraml_req), 68'd1);
        wait_idle("t1_done");

        // 2: single boot read on the inst side.
        send_inst(1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C08_BFAF);
        wait_idle("t2_done");

        // 3: data write vs inst read; data first, latch stable while masters move on.
        data_lat = 2;
        send_data(1'b1, 2'd1, 32'hBFAF_8000, 32'h0000_1234);
        send_inst(1'b0, 2'd2, 32'hBFC0_0004, 32'h0);
        expect_txn(1'b1, 1'b1, 2'd1, 32'hBFAF_8000, 32'h0000_1234, 32'h8000_BFAF);
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 32'h0004_BFC0);
        wait_idle("t3_done");
        data_lat = 0;

        // 4: starvation cap, both masters saturated.
        order = "DDDDIDDDDIDDI";
        for (int k = 0; k < 10; k++) send_data(1'b0, 2'd2, 32'h0000_1000 + 32'(k * 4), 32'h0);
        for (int k = 0; k < 3; k++)  send_inst(1'b0, 2'd2, 32'h0000_2000 + 32'(k * 4), 32'h0);
        di = 0;
        ii = 0;
        for (int i = 0; i < order.len(); i++) begin
            if (order[i] == "D") begin
                a = 32'h0000_1000 + 32'(di * 4);
                expect_txn(1'b1, 1'b0, 2'd2, a, 32'h0, stub_rd(a));
                di++;
            end else begin
                a = 32'h0000_2000 + 32'(ii * 4);
                expect_txn(1'b0, 1'b0, 2'd2, a, 32'h0, stub_rd(a));
                ii++;
            end
        end
        wait_idle("t4_done");

        // 5: bridge completes in the accept cycle.
        same_cycle = 1'b1;
        same_base = same_cnt;
        send_data(1'b1, 2'd0, 32'h0000_0300, 32'h0000_00A5);
        send_data(1'b1, 2'd0, 32'h0000_0304, 32'h0000_005A);
        expect_txn(1'b1, 1'b1, 2'd0, 32'h0000_0300, 32'h0000_00A5, 32'h0300_0000);
        expect_txn(1'b1, 1'b1, 2'd0, 32'h0000_0304, 32'h0000_005A, 32'h0304_0000);
        wait_idle("t5_done");
        check("t5_same_cycle_pulses", 68'(same_cnt - same_base), 68'd2);
        check("t5_grant_gap", 68'(last_ok_cyc - prev_ok_cyc), 68'd2);
        same_cycle = 1'b0;

        // 6: reset while waiting for data; no data_ok, then a clean read.
        data_lat = 5;
        send_inst(1'b0, 2'd2, 32'h0000_0400, 32'h0);
        cmd_q.push_back('{m: 1'b0, wr: 1'b0, size: 2'd2, addr: 32'h0000_0400, wdata: 32'h0});
        for (int n = 0; n < 20 && !inst_addr_ok; n++) @(negedge clk);
        check("t6_addr_ok_seen", 68'(inst_addr_ok), 68'd1);
        @(negedge clk);
        resetn = 1'b0;
        inst_mq.delete();
        data_mq.delete();
        #1;
        check("t6_reset_quiet", 68'({sraml_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 68'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_reset_quiet", 68'({sraml_req, inst_data_ok, data_data_ok}), 68'd0);
        end
        resetn = 1'b1;
        data_lat = 1;
        repeat (3) begin
            @(negedge clk);
            check("t6_idle_after_reset", 68'({sraml_req, inst_data_ok, data_data_ok}), 68'd0);
        end
        send_inst(1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C08_BFAF);
        wait_idle("t6_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
